fetch_step_ctrl: RTL
====================

Name: fetch_step_ctrl

Overview:
Sequences the instruction fetch unit for board-level debugging. It issues single-cycle PC-advance enables either from a slow free-running divider (RUN) or from a debounced push-button (STEP). It can halt automatically at a breakpoint address. It sits between the board I/O and the fetch unit's PC-write enable, next to the seven-segment display path.

Parameters:
RUN_DIV, 100000000, clock cycles between PC advances in RUN (1 Hz at 100 MHz); minimum 2
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a button level change; minimum 1
CNT_W, 27, width of divider and debounce counters; must hold max(RUN_DIV, DEBOUNCE_CYCLES)

Ports:
Clk  input  1  system clock; all state changes on rising edge
Reset  input  1  asynchronous, active-low reset
BtnStep  input  1  raw asynchronous step push-button, high = pressed
SwRun  input  1  raw asynchronous mode switch, 1 = RUN, 0 = STEP
SwBrkEn  input  1  raw breakpoint enable switch
BrkAddr  input  32  breakpoint PC value; quasi-static
PC  input  32  current PC of the fetch unit
PcEn  output  1  one-cycle PC-advance strobe to the fetch unit
State  output  2  00 = STEP, 01 = RUN, 10 = HALT
HaltLed  output  1  high while in HALT
StepCount  output  16  number of PcEn pulses issued; wraps at 16'hFFFF -> 0

Behaviour:
- Reset low (asynchronous): State = STEP, PcEn = 0, HaltLed = 0, StepCount = 0, divider = 0, debounce stable level = 0, synchronizers = 0.
- Input conditioning:
  - BtnStep, SwRun and SwBrkEn each pass through a 2-flop synchronizer.
  - BtnStep is debounced: the stable level flips only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle clears the counter.
  - Press = a one-cycle pulse on a stable 0->1 transition. Release generates nothing.
  - Switches are synchronized only, not debounced.
- STEP:
  - Press -> PcEn high for exactly the next cycle; StepCount increments in the same cycle.
  - Synchronized SwRun = 1 -> RUN, with the divider cleared to 0.
- RUN:
  - The divider counts 0 .. RUN_DIV-1 and wraps.
  - At terminal count (RUN_DIV-1):
    - if synchronized SwBrkEn = 1 and PC == BrkAddr -> HALT, no PcEn pulse;
    - otherwise PcEn pulses high for one cycle.
  - The first pulse occurs RUN_DIV cycles after entering RUN.
  - Presses are ignored.
  - SwRun = 0 -> STEP, with the divider cleared.
- HALT:
  - HaltLed = 1; no PcEn pulses.
  - Press -> one PcEn pulse, then STEP. This releases the breakpoint without re-triggering.
  - SwRun = 0 -> STEP with no pulse.
  - SwRun remaining 1 keeps HALT.
- Priority on simultaneous events:
  - In STEP, a SwRun rise beats a same-cycle Press; the Press is dropped.
  - In HALT, SwRun = 0 beats Press; no pulse is issued.
- PcEn is never high in two consecutive cycles. Every PcEn pulse increments StepCount by exactly 1.
- Outputs are registered. HaltLed and State are decoded from the state register.
- Reset asserted mid-operation: all state is cleared immediately and asynchronously. A PcEn pulse in flight is truncated.
- BrkAddr is compared as full 32 bits; there is no alignment masking.

Decomposition:
- Shared package holds the state encodings (ST_STEP = 2'b00, ST_RUN = 2'b01, ST_HALT = 2'b10) and the default RUN_DIV / DEBOUNCE_CYCLES constants.
- Natural sub-module: btn_debounce, containing the synchronizer, debounce counter, stable level and rising-edge Press pulse, parameterised by DEBOUNCE_CYCLES.
- The FSM, divider and StepCount stay in fetch_step_ctrl.

Test Plan:
All scenarios run with RUN_DIV = 4 and DEBOUNCE_CYCLES = 3.
1. Reset, then hold BtnStep = 1 for 10 cycles -> exactly one PcEn pulse, StepCount = 1, State = 00; a second press/release gives StepCount = 2.
2. Toggle BtnStep 1-0-1 every cycle for 8 cycles, then hold 0 -> no PcEn, StepCount unchanged (bounce rejected).
3. SwRun = 1 with SwBrkEn = 0 for 40 cycles -> PcEn every 4th cycle, never back-to-back; StepCount matches the pulse count; State = 01.
4. RUN with SwBrkEn = 1, BrkAddr = 32'h0000_0008, PC driven to 8 -> at the next terminal count State = 10, HaltLed = 1, no PcEn; then a press -> one PcEn, State = 00.
5. StepCount preloaded near wrap by issuing 65535 pulses in RUN, then one more -> StepCount = 0.
6. Assert Reset = 0 asynchronously mid-RUN, between clock edges -> outputs clear immediately (PcEn = 0, State = 00, StepCount = 0); after release, no PcEn until a new press or a RUN entry.

Source files
------------

// File: rtl/fetch_step_ctrl_pkg.sv
// Shared types and default constants for the fetch single-step / run controller.
package fetch_step_ctrl_pkg;

  typedef enum logic [1:0] {
    StStep = 2'b00,
    StRun  = 2'b01,
    StHalt = 2'b10
  } state_e;

  localparam int unsigned RunDivDefault         = 100_000_000;
  localparam int unsigned DebounceCyclesDefault = 1_000_000;
  localparam int unsigned CntWDefault           = 27;

endpackage

// File: rtl/fetch_step_ctrl_btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, debounce counter, stable level and a
// one-cycle press pulse on each accepted 0->1 transition.
module fetch_step_ctrl_btn_debounce
  import fetch_step_ctrl_pkg::*;
#(
  parameter int unsigned DebounceCycles = DebounceCyclesDefault,
  parameter int unsigned CntW           = CntWDefault
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  logic [1:0]      sync_q;
  logic            stable_q, stable_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter only advances while the synchronized level disagrees; any agreement clears it.
  always_comb begin
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CntW'(DebounceCycles - 1)) begin
        stable_d = sync_q[1];
        press_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/fetch_step_ctrl.sv
// Board-debug fetch sequencer: issues one-cycle PC-advance strobes from a debounced step
// button (STEP) or a free-running divider (RUN), with an optional breakpoint halt.
module fetch_step_ctrl
  import fetch_step_ctrl_pkg::*;
#(
  parameter int unsigned RunDiv         = RunDivDefault,
  parameter int unsigned DebounceCycles = DebounceCyclesDefault,
  parameter int unsigned CntW           = CntWDefault,
  parameter int unsigned StepW          = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             btn_step_i,
  input  logic             sw_run_i,
  input  logic             sw_brk_en_i,
  input  logic [31:0]      brk_addr_i,
  input  logic [31:0]      pc_i,
  output logic             pc_en_o,
  output logic [1:0]       state_o,
  output logic             halt_led_o,
  output logic [StepW-1:0] step_count_o
);

  state_e           state_q, state_d;
  logic [CntW-1:0]  div_q, div_d;
  logic             pc_en_q, pc_en_d;
  logic [StepW-1:0] step_cnt_q, step_cnt_d;
  logic [1:0]       run_sync_q, brk_sync_q;
  logic             press;
  logic             run, div_term, brk_hit;

  fetch_step_ctrl_btn_debounce #(
    .DebounceCycles(DebounceCycles),
    .CntW          (CntW)
  ) u_btn_debounce (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .btn_i  (btn_step_i),
    .press_o(press)
  );

  assign run      = run_sync_q[1];
  assign div_term = (div_q == CntW'(RunDiv - 1));
  assign brk_hit  = brk_sync_q[1] && (pc_i == brk_addr_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StStep;
      div_q      <= '0;
      pc_en_q    <= 1'b0;
      step_cnt_q <= '0;
      run_sync_q <= '0;
      brk_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      pc_en_q    <= pc_en_d;
      step_cnt_q <= step_cnt_d;
      run_sync_q <= {run_sync_q[0], sw_run_i};
      brk_sync_q <= {brk_sync_q[0], sw_brk_en_i};
    end
  end

  // Divider stays at zero outside RUN, so every RUN entry starts a full period.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    unique case (state_q)
      StStep: begin
        if (run) state_d = StRun;
      end
      StRun: begin
        if (!run) begin
          state_d = StStep;
        end else if (div_term) begin
          if (brk_hit) state_d = StHalt;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StHalt: begin
        if (!run || press) state_d = StStep;
      end
      default: state_d = StStep;
    endcase
  end

  // SwRun changes take priority over a same-cycle press in both STEP and HALT.
  always_comb begin
    pc_en_d = 1'b0;
    unique case (state_q)
      StStep:  pc_en_d = press && !run;
      StRun:   pc_en_d = run && div_term && !brk_hit;
      StHalt:  pc_en_d = press && run;
      default: pc_en_d = 1'b0;
    endcase
    step_cnt_d = step_cnt_q + StepW'(pc_en_d);
  end

  assign pc_en_o      = pc_en_q;
  assign state_o      = state_q;
  assign halt_led_o   = (state_q == StHalt);
  assign step_count_o = step_cnt_q;

endmodule
